// File: rtl/ita_package.sv
// Shared ITA types and sizes used by the output FIFO and its neighbours.
package ita_package;

    // Bit width of one output element
    localparam int unsigned WI = 8;
    // Number of elements packed into one FIFO word
    localparam int unsigned N = 4;
    // Default number of output FIFO entries
    localparam int unsigned FifoDepth = 4;

    // One output FIFO word: N elements of WI bits each
    typedef logic [N*WI-1:0] fifo_data_t;

endpackage : ita_package

// File: rtl/ita_output_fifo.sv
// First-word-fall-through output FIFO.
// Storage is a flip-flop array. Occupancy is kept in a registered counter,
// and full/empty/almost_full are decoded from that counter.
// The data array itself is never reset.
module ita_output_fifo
    import ita_package::*;
#(
    parameter int unsigned DEPTH          = FifoDepth,
    parameter int unsigned ALMOST_FULL_TH = DEPTH - 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fifo_data_t                 data_i,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output fifo_data_t                 data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] usage_o,
    output logic                       overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fifo_data_t             mem [DEPTH];
    logic       [PTR_W-1:0] wr_ptr;
    logic       [PTR_W-1:0] rd_ptr;
    logic       [CNT_W-1:0] usage_q;
    logic                   overflow_q;
    logic                   pop;
    logic                   push_ok;
    logic                   push_drop;

    // Advance a pointer with an explicit wrap, so that a DEPTH that is not
    // a power of two also works.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Decode the status flags from the registered occupancy count
    always_comb begin
        empty_o       = (usage_q == '0);
        full_o        = (usage_q == CNT_W'(DEPTH));
        almost_full_o = (usage_q >= CNT_W'(ALMOST_FULL_TH));
        valid_o       = !empty_o;
        usage_o       = usage_q;
        overflow_o    = overflow_q;
        data_o        = empty_o ? '0 : mem[rd_ptr];
    end

    // Handshake decode.
    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle.
    always_comb begin
        pop       = valid_o && ready_i;
        push_ok   = push_i && (!full_o || pop);
        push_drop = push_i && full_o && !pop;
    end

    // Write the data array. Clear has priority, so no write happens while it
    // is asserted.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Update pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            usage_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            usage_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop})
                2'b10:   usage_q <= usage_q + CNT_W'(1);
                2'b01:   usage_q <= usage_q - CNT_W'(1);
                default: usage_q <= usage_q;
            endcase
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule : ita_output_fifo

// File: tb/tb_ita_output_fifo.sv
// Testbench for ita_output_fifo, built around a queue-based reference model.
module tb_ita_output_fifo;
    import ita_package::*;

    localparam int unsigned DEPTH = FifoDepth;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            clear_i = 1'b0;
    logic            push_i = 1'b0;
    logic            ready_i = 1'b0;
    fifo_data_t      data_i = '0;
    logic            full_o, almost_full_o, valid_o, empty_o, overflow_o;
    fifo_data_t      data_o;
    logic [CW-1:0]   usage_o;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: the contents in order, plus the sticky overflow flag
    fifo_data_t m_q[$];
    bit         m_ovf = 1'b0;

    ita_output_fifo #(.DEPTH(DEPTH), .ALMOST_FULL_TH(DEPTH - 1)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .push_i(push_i),
        .data_i(data_i), .full_o(full_o), .almost_full_o(almost_full_o),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .empty_o(empty_o), .usage_o(usage_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        chk("valid",  valid_o, m_q.size() > 0);
        chk("empty",  empty_o, m_q.size() == 0);
        chk("full",   full_o,  m_q.size() == DEPTH);
        chk("afull",  almost_full_o, m_q.size() >= DEPTH - 1);
        chk("usage",  usage_o, m_q.size());
        chk("ovf",    overflow_o, m_ovf);
        chk("data",   data_o, (m_q.size() > 0) ? m_q[0] : fifo_data_t'(0));
    end

    // One clock: update the model from the inputs seen at the edge, then
    // step 1 ns past the edge so the caller can drive the next inputs.
    task automatic cycle();
        bit pop, acc;
        @(posedge clk);
        if (rst_i || clear_i) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop = (m_q.size() > 0) && ready_i;
            acc = push_i && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(data_i);
            if (push_i && !acc) m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic push_word(input fifo_data_t d);
        push_i = 1'b1; data_i = d; cycle(); push_i = 1'b0;
    endtask

    initial begin
        fifo_data_t exp_v;
        // Reset state
        cycle(); cycle();
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_usage", usage_o, 0);
        chk("rst_data",  data_o, 0);
        rst_i = 1'b0;
        cycle();

        // Push A, B, C, then drain them in order
        push_i = 1'b1; data_i = 32'hA; cycle();
        chk("lat1_valid", valid_o, 1'b1);
        chk("lat1_data",  data_o, 32'hA);
        data_i = 32'hB; cycle();
        data_i = 32'hC; cycle();
        push_i = 1'b0; ready_i = 1'b1;
        chk("drain_A", data_o, 32'hA); cycle();
        chk("drain_B", data_o, 32'hB); cycle();
        chk("drain_C", data_o, 32'hC); cycle();
        chk("drained_empty", empty_o, 1'b1);
        ready_i = 1'b0;

        // Fill to full, then drop a fifth push
        for (int i = 0; i < 4; i++) begin
            push_word(32'h100 + i);
            if (i == 2) chk("afull_at3", almost_full_o, 1'b1);
        end
        chk("full4", full_o, 1'b1);
        chk("usage4", usage_o, 4);
        push_word(32'h1FF);
        chk("ovf_set", overflow_o, 1'b1);
        chk("head_kept", data_o, 32'h100);

        // Full FIFO with push and pop in the same cycle
        clear_i = 1'b1; cycle(); clear_i = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h200 + i);
        ready_i = 1'b1; push_word(32'h2AA); ready_i = 1'b0;
        chk("pp_usage", usage_o, 4);
        chk("pp_ovf", overflow_o, 1'b0);
        chk("pp_head", data_o, 32'h201);
        clear_i = 1'b1; cycle(); clear_i = 1'b0;

        // Ten interleaved words; the pointers wrap twice
        exp_v = 0;
        ready_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            push_i = (i < 10); data_i = i;
            if (valid_o) begin
                chk("seq", data_o, exp_v);
                exp_v++;
            end
            cycle();
        end
        push_i = 1'b0; ready_i = 1'b0;
        chk("seq_count", exp_v, 10);

        // Clear while pushing, with usage 2 and overflow set
        for (int i = 0; i < 5; i++) push_word(32'h300 + i);
        ready_i = 1'b1; cycle(); cycle(); ready_i = 1'b0;
        chk("pre_clr_usage", usage_o, 2);
        chk("pre_clr_ovf", overflow_o, 1'b1);
        clear_i = 1'b1; push_i = 1'b1; data_i = 32'h3EE; cycle();
        clear_i = 1'b0; push_i = 1'b0;
        chk("clr_usage", usage_o, 0);
        chk("clr_empty", empty_o, 1'b1);
        chk("clr_ovf", overflow_o, 1'b0);
        cycle();
        chk("clr_absent", valid_o, 1'b0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) push_word(32'h400 + i);
        rst_i = 1'b1; #1;
        chk("arst_usage", usage_o, 0);
        chk("arst_valid", valid_o, 1'b0);
        chk("arst_data", data_o, 0);
        m_q.delete(); m_ovf = 1'b0;
        cycle();
        rst_i = 1'b0;
        push_word(32'h5A5A);
        chk("post_rst_head", data_o, 32'h5A5A);
        chk("post_rst_usage", usage_o, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            push_i  = $urandom_range(0, 99) < 60;
            ready_i = $urandom_range(0, 99) < 45;
            clear_i = $urandom_range(0, 99) < 3;
            data_i  = $urandom;
            cycle();
        end
        push_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0;
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ita_output_fifo

// File: doc/ita_output_fifo.md
ITA_OUTPUT_FIFO -- requirements
Module: ita_output_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default FifoDepth (ita_package, 4), number of fifo_data_t entries, legal range 2..64.
REQ-002 SHALL have parameter ALMOST_FULL_TH, default DEPTH-1, usage at or above which almost_full_o asserts.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear_i  input  1  synchronous flush.
REQ-006 SHALL have port push_i  input  1  write strobe from the requantizer/FIFO-controller stage.
REQ-007 SHALL have port data_i  input  fifo_data_t  write word.
REQ-008 SHALL have port full_o  output  1  usage == DEPTH.
REQ-009 SHALL have port almost_full_o  output  1  usage >= ALMOST_FULL_TH.
REQ-010 SHALL have port valid_o  output  1  head entry available (= !empty).
REQ-011 SHALL have port ready_i  input  1  downstream accepts head entry.
REQ-012 SHALL have port data_o  output  fifo_data_t  head entry.
REQ-013 SHALL have port empty_o  output  1  usage == 0.
REQ-014 SHALL have port usage_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have port overflow_o  output  1  sticky: push dropped.

Function
REQ-016 SHALL be first-word-fall-through: data_o = mem[rd_ptr] combinationally while valid_o=1; data_o SHALL be '0 when empty.
REQ-017 SHALL pop when valid_o && ready_i; ready_i while empty SHALL have no effect.
REQ-018 SHALL accept a push when !full_o, or when full_o and a pop occurs in the same cycle.
REQ-019 SHALL drop a push when full_o and no pop in that cycle; usage and memory unchanged; overflow_o set next cycle.
REQ-020 SHALL make a word written into an empty FIFO visible on valid_o/data_o the cycle after push (latency 1); no same-cycle bypass.
REQ-021 SHALL keep usage unchanged on simultaneous accepted push and pop, including at usage 0 (push-only effect since valid_o=0) handled per REQ-017/018.
REQ-022 SHALL advance wr_ptr/rd_ptr modulo DEPTH with explicit wrap at DEPTH-1 (non-power-of-two DEPTH legal).
REQ-023 SHALL derive full_o, empty_o, almost_full_o from a registered usage counter, never from pointer compare alone.
REQ-024 SHALL, on clear_i, zero pointers, usage and overflow_o next cycle, ignoring push/pop in that cycle (clear has priority).
REQ-025 SHALL hold overflow_o until clear_i or reset.
REQ-026 SHALL not require memory contents to be reset; only pointers, usage, overflow_o.

Reset
REQ-027 SHALL, while rst_i=1, immediately force rd_ptr=0, wr_ptr=0, usage=0, overflow_o=0, giving empty_o=1, valid_o=0, full_o=0, almost_full_o=0, usage_o=0, data_o='0.
REQ-028 SHALL discard all stored entries on reset mid-operation; first push after deassertion behaves as into an empty FIFO.

Structure
REQ-029 SHALL take fifo_data_t, WI, N and FifoDepth from ita_package; no new package types required.
REQ-030 SHALL be a single module; storage as flip-flop array, no sub-module.

Verification
REQ-031 SHALL cover: reset, push A,B,C (DEPTH=4), ready_i=1 from cycle 5 -> valid_o 1 cycle after first push, data_o A,B,C in order, then empty_o=1.
REQ-032 SHALL cover: 4 pushes, ready_i=0 -> full_o=1, usage_o=4, almost_full_o=1 from usage 3; 5th push dropped, overflow_o=1 next cycle, head still first word.
REQ-033 SHALL cover: full, push X with ready_i=1 same cycle -> X accepted, usage_o stays 4, overflow_o stays 0.
REQ-034 SHALL cover: 10 push/pop interleaved words 0..9 -> pointers wrap twice, output sequence 0..9 exactly.
REQ-035 SHALL cover: usage 2, overflow_o=1, clear_i with push_i=1 -> next cycle usage_o=0, empty_o=1, overflow_o=0, pushed word absent.
REQ-036 SHALL cover: rst_i asserted mid-burst at usage 3 -> outputs at reset values without clock edge; post-reset push Y appears as sole entry.
